// File: rtl/mod10_pkg.sv
// rtl/mod10_pkg.sv - shared constants, digit type and wrap helper for the decade counter
package mod10_pkg;

    localparam int MOD10_WIDTH   = 4;
    localparam int MOD10_MODULUS = 10;

    typedef logic [MOD10_WIDTH-1:0] bcd_digit_t;

    // Next value of a default-size digit stepping one place, wrapping at both ends.
    // Any out-of-range value is treated as the top digit, so an up-step lands on 0.
    function automatic bcd_digit_t bcd_next(input bcd_digit_t value, input logic down);
        bcd_digit_t last;
        last = bcd_digit_t'(MOD10_MODULUS - 1);
        if (down) begin
            if (value == '0)
                bcd_next = last;
            else if (value > last)
                bcd_next = last - 1'b1;
            else
                bcd_next = value - 1'b1;
        end else begin
            if (value >= last)
                bcd_next = '0;
            else
                bcd_next = value + 1'b1;
        end
    endfunction

endpackage

// File: rtl/mod10_counter.sv
// rtl/mod10_counter.sv - synchronous BCD decade counter with load, clear, enable and carry (optional MOD10_UPDOWN_EN adds down-count)
module mod10_counter
    import mod10_pkg::*;
#(
    parameter int WIDTH   = MOD10_WIDTH,
    parameter int MODULUS = MOD10_MODULUS
) (
    input  logic             clock,
    input  logic             reset,
`ifdef MOD10_UPDOWN_EN
    input  logic             down,
`endif
    input  logic [WIDTH-1:0] data,
    input  logic             loadn,
    input  logic             clrn,
    input  logic             enable,
    output logic [WIDTH-1:0] ones,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             dir_down;
    logic             at_last;
    logic             at_zero;
    logic             data_ok;
    logic [WIDTH-1:0] step_value;

`ifdef MOD10_UPDOWN_EN
    assign dir_down = down;
`else
    assign dir_down = 1'b0;
`endif

    // Illegal states count as the top digit, so they fall into the wrap path.
    assign at_last = (ones >= LAST);
    assign at_zero = (ones == '0);
    assign data_ok = ({1'b0, data} < MOD_EXT);

    // Next value when counting: wrap at the top going up, at zero going down.
    always_comb begin
        step_value = '0;
        if (dir_down) begin
            if (at_zero)
                step_value = LAST;
            else if (ones > LAST)
                step_value = LAST - 1'b1;
            else
                step_value = ones - 1'b1;
        end else begin
            if (at_last)
                step_value = '0;
            else
                step_value = ones + 1'b1;
        end
    end

    // Carry/borrow only when a plain count will actually wrap this edge.
    always_comb begin
        tc = enable & clrn & loadn & ~reset & (dir_down ? at_zero : (ones == LAST));
    end

    // Count register: reset, clear, load, count, hold in priority order.
    always_ff @(posedge clock) begin
        if (reset)
            ones <= '0;
        else if (!clrn)
            ones <= '0;
        else if (!loadn)
            ones <= data_ok ? data : '0;
        else if (enable)
            ones <= step_value;
    end

endmodule

// File: tb/tb_mod10_counter.sv
// tb/tb_mod10_counter.sv - scoreboard bench for mod10_counter (also builds with MOD10_UPDOWN_EN)
module tb_mod10_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       down  = 1'b0;
    logic [3:0] data  = 4'd0;
    logic       loadn = 1'b1;
    logic       clrn  = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] ones;
    logic       tc;

    logic       c_reset = 1'b0;
    logic       c_en    = 1'b0;
    logic [3:0] lo_ones, hi_ones;
    logic       lo_tc, hi_tc;

    always #5 clock = ~clock;

    mod10_counter dut (
        .clock  (clock),
        .reset  (reset),
`ifdef MOD10_UPDOWN_EN
        .down   (down),
`endif
        .data   (data),
        .loadn  (loadn),
        .clrn   (clrn),
        .enable (enable),
        .ones   (ones),
        .tc     (tc)
    );

    mod10_counter u_lo (
        .clock  (clock),
        .reset  (c_reset),
`ifdef MOD10_UPDOWN_EN
        .down   (1'b0),
`endif
        .data   (4'd0),
        .loadn  (1'b1),
        .clrn   (1'b1),
        .enable (c_en),
        .ones   (lo_ones),
        .tc     (lo_tc)
    );

    mod10_counter u_hi (
        .clock  (clock),
        .reset  (c_reset),
`ifdef MOD10_UPDOWN_EN
        .down   (1'b0),
`endif
        .data   (4'd0),
        .loadn  (1'b1),
        .clrn   (1'b1),
        .enable (lo_tc),
        .ones   (hi_ones),
        .tc     (hi_tc)
    );

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    exp_t       sb[$];
    int         passed = 0;
    int         failed = 0;
    int         total  = 0;
    logic [3:0] m;

    task automatic compare(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_push(input string tag, input logic [3:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_pop(input logic [3:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            compare("scoreboard_empty", 4'd1, 4'd0);
        end else begin
            e = sb.pop_front();
            compare(e.tag, obs, e.val);
        end
    endtask

    // One clock of stimulus: predict tc for this cycle and ones after the edge.
    task automatic step(input logic r, input logic c, input logic l, input logic [3:0] d,
                        input logic e, input logic dn, input string tag);
        logic       exp_tc;
        logic [3:0] nxt;
        reset = r; clrn = c; loadn = l; data = d; enable = e; down = dn;
        exp_tc = e & c & l & ~r & (dn ? (m == 4'd0) : (m == 4'd9));
        if (r || !c)       nxt = 4'd0;
        else if (!l)       nxt = (d < 4'd10) ? d : 4'd0;
        else if (e && dn)  nxt = (m == 4'd0) ? 4'd9 : m - 4'd1;
        else if (e)        nxt = (m == 4'd9) ? 4'd0 : m + 4'd1;
        else               nxt = m;
        expect_push({tag, ".tc"}, {3'b000, exp_tc});
        expect_push(tag, nxt);
        #1;
        expect_pop({3'b000, tc});
        @(posedge clock);
        m = nxt;
        #1;
        expect_pop(ones);
    endtask

    logic [3:0] up_seq [12];
    logic [3:0] dn_seq [12];

    initial begin
        up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        dn_seq = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        m = 'x;
        @(posedge clock);
        #1;

        step(1, 1, 1, 4'd10, 0, 0, "reset");
        compare("reset_ones_const", ones, 4'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 4'd0, 0, 0, "hold_idle");
        compare("hold_ones_const", ones, 4'd0);

        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 4'd0, 1, 0, "count_up");
            compare("count_up_table", ones, up_seq[i]);
        end

        step(0, 1, 0, 4'd7, 1, 0, "load7_with_enable");
        compare("load7_const", ones, 4'd7);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 4'd0, 1, 0, "after_load");
        compare("after_load_wrap_const", ones, 4'd0);
        step(0, 1, 0, 4'd10, 0, 0, "load10_rejected");
        step(0, 1, 0, 4'd15, 1, 0, "load15_rejected");
        compare("load_reject_const", ones, 4'd0);

        step(0, 1, 0, 4'd9, 0, 0, "load9");
        step(0, 1, 0, 4'd3, 1, 0, "load_over_tc");
        step(0, 1, 0, 4'd9, 0, 0, "load9b");
        step(0, 0, 1, 4'd0, 1, 0, "clear_over_tc");
        step(0, 1, 0, 4'd9, 0, 0, "load9c");
        step(1, 1, 1, 4'd0, 1, 0, "reset_over_tc");

        step(0, 1, 0, 4'd5, 0, 0, "load5");
        step(0, 0, 0, 4'd3, 1, 0, "clear_beats_load");
        compare("clear_priority_const", ones, 4'd0);
        step(0, 1, 0, 4'd4, 0, 0, "load4");
        step(0, 1, 1, 4'd0, 1, 0, "count5");
        step(0, 1, 1, 4'd0, 1, 0, "count6");
        step(1, 1, 0, 4'd4, 1, 0, "reset_mid_count");
        compare("reset_mid_const", ones, 4'd0);

`ifdef MOD10_UPDOWN_EN
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 4'd0, 1, 1, "count_down");
            compare("count_down_table", ones, dn_seq[i]);
        end
        step(1, 1, 1, 4'd0, 0, 0, "reset_before_up");
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 4'd0, 1, 0, "count_up_again");
            compare("count_up_again_table", ones, up_seq[i]);
        end
`endif

        c_reset = 1'b1;
        c_en = 1'b0;
        @(posedge clock);
        #1;
        c_reset = 1'b0;
        expect_push("cascade_reset_lo", 4'd0);
        expect_pop(lo_ones);
        c_en = 1'b1;
        repeat (25) @(posedge clock);
        #1;
        c_en = 1'b0;
        expect_push("cascade_ones", 4'd5);
        expect_push("cascade_tens", 4'd2);
        expect_push("cascade_tens_tc", 4'd0);
        expect_pop(lo_ones);
        expect_pop(hi_ones);
        expect_pop({3'b000, hi_tc});

        compare("scoreboard_drained", 4'(sb.size()), 4'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
